// File: rtl/pool_pkg.sv
// pool_pkg: shared window size, FSM state encoding and lane/window types
// for the pooling window fetcher.
package pool_pkg;
    localparam int WIN_SIZE = 6;
    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_e;
    typedef logic [7:0] lane_t;
    typedef lane_t [WIN_SIZE-1:0] win_t;
endpackage

// File: rtl/pool_win_buf.sv
// pool_win_buf: 6x8 window capture register with lane-select write,
// full flag (set by the last lane write) and clear.
module pool_win_buf import pool_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       we_i,
    input  logic [2:0] sel_i,
    input  lane_t      din_i,
    output win_t       win_o,
    output logic       full_o
);
    win_t win_q;
    logic full_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (we_i) win_q[sel_i] <= din_i;
            full_q <= (we_i && sel_i == 3'(WIN_SIZE - 1)) ? 1'b1 : clr_i ? 1'b0 : full_q;
        end
    end
    assign win_o  = win_q;
    assign full_o = full_q;
endmodule

// File: rtl/pool_window_fetch.sv
// pool_window_fetch: walks a BRAM region and presents 6-byte windows on ad0..ad5
// with valid/ready. Define POOL_FETCH_PREFETCH_EN for a ping-pong second buffer.
module pool_window_fetch import pool_pkg::*; #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_win,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_dout,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [7:0]        ad0,
    output logic [7:0]        ad1,
    output logic [7:0]        ad2,
    output logic [7:0]        ad3,
    output logic [7:0]        ad4,
    output logic [7:0]        ad5
);
`ifdef POOL_FETCH_PREFETCH_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0] k_q, cap_k_q;
    logic cap_en_q;
    logic [CNT_W-1:0] n_q, w_q;
    logic [NB-1:0] full, we, clr;
    win_t win [NB];
    win_t cur;
    logic hs, last, issue;

    assign hs        = win_valid & win_ready;
    assign last      = w_q == n_q - CNT_W'(1);
    assign busy      = state_q != IDLE && state_q != DONE;
    assign done      = state_q == DONE;
    assign bram_en   = issue;
    assign bram_addr = addr_q;

`ifdef POOL_FETCH_PREFETCH_EN
    logic wsel_q, psel_q, cap_b_q;
    logic [CNT_W-1:0] iw_q;
    // Reads target the write buffer and stall only while it still holds an unconsumed window.
    assign issue     = state_q == FETCH && iw_q != n_q && !full[wsel_q];
    assign win_valid = state_q == FETCH && full[psel_q];
    assign cur       = win[psel_q];
    assign we        = {cap_en_q & cap_b_q, cap_en_q & ~cap_b_q};
    assign clr       = {hs & psel_q, hs & ~psel_q};
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? (num_win == '0 ? DONE : FETCH) : IDLE;
            FETCH:   state_d = (hs && last) ? DONE : FETCH;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == IDLE) begin
            wsel_q  <= 1'b0;
            psel_q  <= 1'b0;
            cap_b_q <= 1'b0;
            iw_q    <= '0;
        end else begin
            wsel_q  <= (issue && k_q == 3'(WIN_SIZE - 1)) ? ~wsel_q : wsel_q;
            iw_q    <= (issue && k_q == 3'(WIN_SIZE - 1)) ? iw_q + CNT_W'(1) : iw_q;
            psel_q  <= hs ? ~psel_q : psel_q;
            cap_b_q <= wsel_q;
        end
    end
`else
    assign issue     = state_q == FETCH;
    assign win_valid = state_q == PRESENT && full[0];
    assign cur       = win[0];
    assign we        = cap_en_q;
    assign clr       = hs;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? (num_win == '0 ? DONE : FETCH) : IDLE;
            FETCH:   state_d = k_q == 3'(WIN_SIZE - 1) ? DRAIN : FETCH;
            DRAIN:   state_d = PRESENT;
            PRESENT: state_d = hs ? (last ? DONE : FETCH) : PRESENT;
            default: state_d = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            k_q      <= '0;
            cap_en_q <= 1'b0;
            cap_k_q  <= '0;
            n_q      <= '0;
            w_q      <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= (state_q == IDLE && start) ? base_addr : issue ? addr_q + ADDR_W'(1) : addr_q;
            k_q      <= issue ? (k_q == 3'(WIN_SIZE - 1) ? 3'd0 : k_q + 3'd1) : k_q;
            cap_en_q <= issue;
            cap_k_q  <= k_q;
            n_q      <= (state_q == IDLE && start) ? num_win : n_q;
            w_q      <= state_q == IDLE ? '0 : hs ? w_q + CNT_W'(1) : w_q;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_buf
        pool_win_buf u_buf (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (clr[b]),
            .we_i   (we[b]),
            .sel_i  (cap_k_q),
            .din_i  (bram_dout),
            .win_o  (win[b]),
            .full_o (full[b])
        );
    end

    assign ad0 = cur[0];
    assign ad1 = cur[1];
    assign ad2 = cur[2];
    assign ad3 = cur[3];
    assign ad4 = cur[4];
    assign ad5 = cur[5];
endmodule

// File: tb/tb_pool_window_fetch.sv
// tb_pool_window_fetch: randomized self-checking bench for the default
// (single-buffer) build against a cycle-level window schedule model.
module tb_pool_window_fetch;
    logic clk = 0, rst_n = 0, start = 0, win_ready = 1;
    logic [9:0] base_addr = '0;
    logic [7:0] num_win = '0;
    logic busy, done, bram_en, win_valid;
    logic [9:0] bram_addr;
    logic [7:0] bram_dout = '0;
    logic [7:0] ad0, ad1, ad2, ad3, ad4, ad5;
    logic [7:0] lanes [6];
    logic [7:0] mem [1024];
    int checks = 0, errors = 0;

    pool_window_fetch #(.ADDR_W(10), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_win(num_win),
        .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .win_valid(win_valid), .win_ready(win_ready),
        .ad0(ad0), .ad1(ad1), .ad2(ad2), .ad3(ad3), .ad4(ad4), .ad5(ad5)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];
    always_comb lanes = '{ad0, ad1, ad2, ad3, ad4, ad5};

    task automatic check_idle_zero(input string nm);
        checks++;
        if ({busy, done, bram_en, win_valid} !== 4'b0 || bram_addr !== 10'd0 ||
            {ad0, ad1, ad2, ad3, ad4, ad5} !== 48'd0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b en=%b valid=%b addr=%h lanes=%h, want all 0", nm,
                     busy, done, bram_en, win_valid, bram_addr, {ad0, ad1, ad2, ad3, ad4, ad5});
        end
    endtask

    // Model: window w's reads occupy cycles s..s+5, it is valid from s+7 until accepted,
    // and the next window's reads start the cycle after acceptance.
    task automatic run(input logic [9:0] b, input int n, input int mode, input bit ign, input string nm);
        int s = 1, w = 0, dc = (n == 0) ? 1 : 0, cyc;
        bit en_e, v_e, rdy;
        logic [9:0] ea;
        @(negedge clk);
        base_addr = b;
        num_win = 8'(n);
        start = 1;
        win_ready = (mode != 1);
        for (cyc = 1; cyc <= 500; cyc++) begin
            @(negedge clk);
            start = 0;
            en_e = w < n && cyc >= s && cyc <= s + 5;
            v_e = w < n && cyc >= s + 7;
            checks += 4;
            if (bram_en !== en_e) begin errors++; $display("FAIL %s en c%0d: got %b want %b", nm, cyc, bram_en, en_e); end
            if (win_valid !== v_e) begin errors++; $display("FAIL %s valid c%0d: got %b want %b", nm, cyc, win_valid, v_e); end
            if (done !== (cyc == dc)) begin errors++; $display("FAIL %s done c%0d: got %b want %b", nm, cyc, done, cyc == dc); end
            if (busy !== (n > 0 && (dc == 0 || cyc < dc))) begin errors++; $display("FAIL %s busy c%0d: got %b", nm, cyc, busy); end
            if (en_e) begin
                ea = b + 10'(6 * w + cyc - s);
                checks++;
                if (bram_addr !== ea) begin errors++; $display("FAIL %s addr c%0d: got %h want %h", nm, cyc, bram_addr, ea); end
            end
            if (v_e) for (int i = 0; i < 6; i++) begin
                ea = b + 10'(6 * w + i);
                checks++;
                if (lanes[i] !== mem[ea]) begin errors++; $display("FAIL %s lane%0d w%0d: got %h want %h", nm, i, w, lanes[i], mem[ea]); end
            end
            if (cyc == dc) break;
            rdy = mode == 0 ? 1'b1 : mode == 1 ? !(w == 0 && cyc < s + 17) : 1'($urandom_range(0, 1));
            win_ready = rdy;
            if (v_e && rdy) begin
                w++;
                s = cyc + 1;
                if (w == n) dc = cyc + 1;
            end
            if (ign && cyc == 3) begin
                start = 1;
                base_addr = 10'($urandom);
                num_win = 8'($urandom_range(1, 9));
            end
        end
        if (cyc > 500) begin
            errors++;
            $display("FAIL %s timeout: done not seen within 500 cycles", nm);
        end
        win_ready = 1;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1;
        @(negedge clk);
        check_idle_zero("post_reset_idle");
    endtask

    task automatic test_single;
        for (int i = 0; i < 6; i++) mem[i] = 8'(i + 1);
        run(10'h000, 1, 0, 0, "single");
    endtask

    task automatic test_back_pressure;
        run(10'h010, 2, 1, 0, "backpressure");
    endtask

    task automatic test_wrap;
        run(10'h3FC, 1, 0, 0, "wrap");
    endtask

    task automatic test_zero_and_ignored_start;
        run(10'($urandom), 0, 0, 0, "zero");
        run(10'($urandom), 2, 2, 1, "ignored_start");
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk);
        base_addr = 10'h020;
        num_win = 8'd3;
        start = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 0;
        end
        rst_n = 0;
        @(negedge clk);
        check_idle_zero("mid_reset");
        rst_n = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (win_valid !== 1'b0 || bram_en !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet c%0d: valid=%b en=%b want 0", c, win_valid, bram_en);
            end
        end
        run(10'h000, 1, 0, 0, "after_reset");
    endtask

    task automatic test_random;
        for (int r = 0; r < 6; r++) run(10'($urandom), int'($urandom_range(1, 5)), 2, 0, "random");
        run(10'($urandom), 4, 0, 0, "back_to_back");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        test_reset;
        test_single;
        test_back_pressure;
        test_wrap;
        test_zero_and_ignored_start;
        test_reset_mid_run;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
